// File: rtl/pwm_deadtime.sv
// Complementary high/low gate drive with a programmable dead interval.
// Optional early return to the released side: PWM_DEADTIME_ABORT_EN.
module pwm_deadtime #(
    parameter int DEAD_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pwm_in,
    input  logic enable,
    output logic high_out,
    output logic low_out,
    output logic dead_active
);

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        LOW_ON  = 2'd1,
        DEAD    = 2'd2,
        HIGH_ON = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwm_q;
    logic             abort_lo, abort_hi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_q   <= 1'b0;
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            pwm_q   <= pwm_in;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PWM_DEADTIME_ABORT_EN
    state_t src_q;

    // Remember which state the dead interval was entered from.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= OFF;
        end else if (state_d == DEAD && state_q != DEAD) begin
            src_q <= state_q;
        end
    end

    assign abort_lo = (src_q == LOW_ON)  && !pwm_q;
    assign abort_hi = (src_q == HIGH_ON) &&  pwm_q;
`else
    assign abort_lo = 1'b0;
    assign abort_hi = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d = DEAD;
                    cnt_d   = CNT_LOAD;
                end
                LOW_ON: begin
                    if (pwm_q) begin
                        state_d = DEAD;
                        cnt_d   = CNT_LOAD;
                    end
                end
                HIGH_ON: begin
                    if (!pwm_q) begin
                        state_d = DEAD;
                        cnt_d   = CNT_LOAD;
                    end
                end
                DEAD: begin
                    if (abort_lo) begin
                        state_d = LOW_ON;
                        cnt_d   = '0;
                    end else if (abort_hi) begin
                        state_d = HIGH_ON;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        // Destination follows the level seen now.
                        state_d = pwm_q ? HIGH_ON : LOW_ON;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign high_out    = (state_q == HIGH_ON);
    assign low_out     = (state_q == LOW_ON);
    assign dead_active = (state_q == DEAD);

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized bench for pwm_deadtime: two instances (2 and 15 dead cycles)
// checked every cycle against an event-level reference model.
`timescale 1ns/1ps
module tb_pwm_deadtime;

    localparam int HALF = 5000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pwm_in = 1'b0;
    logic enable = 1'b0;
    logic [1:0] hi, lo, dd;

    int errors = 0;
    int checks = 0;

    int dcy [2] = '{2, 15};

    // reference: conducting flag, which side, dead cycles left, origin side
    bit m_on  [2];
    bit m_hi  [2];
    bit m_pwm [2];
    int m_rem [2];
    int m_from[2];

    int hi_cnt[2];
    int lo_cnt[2];
    int dd_cnt[2];

    pwm_deadtime #(.DEAD_CYCLES(2), .CNT_W(4)) u_dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .pwm_in     (pwm_in),
        .enable     (enable),
        .high_out   (hi[0]),
        .low_out    (lo[0]),
        .dead_active(dd[0])
    );

    pwm_deadtime #(.DEAD_CYCLES(15), .CNT_W(4)) u_dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .pwm_in     (pwm_in),
        .enable     (enable),
        .high_out   (hi[1]),
        .low_out    (lo[1]),
        .dead_active(dd[1])
    );

    always #HALF clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        bit p;
        bit done;
        p = m_pwm[k];
        done = 1'b0;
        if (!enable) begin
            m_on[k]  = 1'b0;
            m_rem[k] = 0;
        end else if (!m_on[k] && m_rem[k] == 0) begin
            m_rem[k]  = dcy[k];
            m_from[k] = -1;
        end else if (m_rem[k] > 0) begin
`ifdef PWM_DEADTIME_ABORT_EN
            if ((m_from[k] == 0 && !p) || (m_from[k] == 1 && p)) begin
                m_rem[k] = 0;
                m_on[k]  = 1'b1;
                m_hi[k]  = p;
                done     = 1'b1;
            end
`endif
            if (!done) begin
                if (m_rem[k] > 1) begin
                    m_rem[k]--;
                end else begin
                    m_rem[k] = 0;
                    m_on[k]  = 1'b1;
                    m_hi[k]  = p;
                end
            end
        end else if (p != m_hi[k]) begin
            m_on[k]   = 1'b0;
            m_rem[k]  = dcy[k];
            m_from[k] = m_hi[k] ? 1 : 0;
        end
        m_pwm[k] = pwm_in;
    endtask

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_on[k]   = 1'b0;
                m_hi[k]   = 1'b0;
                m_pwm[k]  = 1'b0;
                m_rem[k]  = 0;
                m_from[k] = -1;
            end else begin
                model_step(k);
            end
        end
    end

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("high%0d", k), 32'(hi[k]), 32'(m_on[k] && m_hi[k]));
            chk($sformatf("low%0d", k), 32'(lo[k]), 32'(m_on[k] && !m_hi[k]));
            chk($sformatf("dead%0d", k), 32'(dd[k]), 32'(m_rem[k] > 0));
            chk($sformatf("excl%0d", k), 32'(hi[k] & lo[k]), 32'd0);
            hi_cnt[k] += int'(hi[k]);
            lo_cnt[k] += int'(lo[k]);
            dd_cnt[k] += int'(dd[k]);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            hi_cnt[k] = 0;
            lo_cnt[k] = 0;
            dd_cnt[k] = 0;
        end
    endtask

    task automatic cyc(input bit p, input bit en);
        @(negedge clk);
        check_outputs();
        pwm_in = p;
        enable = en;
    endtask

    initial begin
        int exp_off0, exp_off1;
`ifdef PWM_DEADTIME_ABORT_EN
        exp_off0 = 1;
        exp_off1 = 1;
`else
        exp_off0 = 2;
        exp_off1 = 15;
`endif
        clr();
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        // 100% duty
        repeat (30) cyc(1'b1, 1'b1);
        clr();
        repeat (20) cyc(1'b1, 1'b1);
        chk("duty100_dead0", 32'(dd_cnt[0]), 32'd0);
        chk("duty100_dead1", 32'(dd_cnt[1]), 32'd0);
        chk("duty100_high0", 32'(hi_cnt[0]), 32'd20);

        // async reset mid-HIGH_ON
        #(HALF / 2);
        reset_n = 1'b0;
        #1;
        chk("rst_high0", 32'(hi[0]), 32'd0);
        chk("rst_high1", 32'(hi[1]), 32'd0);
        chk("rst_dead1", 32'(dd[1] | lo[1] | lo[0] | dd[0]), 32'd0);
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        clr();
        repeat (3) cyc(1'b1, 1'b1);
        chk("rst_rel_dead0", 32'(dd_cnt[0]), 32'd2);
        chk("rst_rel_high0", 32'(hi_cnt[0]), 32'd1);

        // 0% duty
        repeat (30) cyc(1'b0, 1'b1);
        clr();
        repeat (20) cyc(1'b0, 1'b1);
        chk("duty0_dead0", 32'(dd_cnt[0]), 32'd0);
        chk("duty0_low0", 32'(lo_cnt[0]), 32'd20);

        // one-cycle pulse while LOW_ON
        clr();
        cyc(1'b1, 1'b1);
        repeat (29) cyc(1'b0, 1'b1);
        chk("pulse_lowoff0", 32'(30 - lo_cnt[0]), 32'(exp_off0));
        chk("pulse_lowoff1", 32'(30 - lo_cnt[1]), 32'(exp_off1));
        chk("pulse_high0", 32'(hi_cnt[0]), 32'd0);
        chk("pulse_high1", 32'(hi_cnt[1]), 32'd0);

        // 50% duty, period 10
        repeat (2) begin
            repeat (5) cyc(1'b1, 1'b1);
            repeat (5) cyc(1'b0, 1'b1);
        end
        clr();
        repeat (10) begin
            repeat (5) cyc(1'b1, 1'b1);
            repeat (5) cyc(1'b0, 1'b1);
        end
        chk("pwm50_high0", 32'(hi_cnt[0]), 32'd30);
        chk("pwm50_dead0", 32'(dd_cnt[0]), 32'd40);

        // enable dropped during DEAD, then re-enabled with pwm high
        repeat (30) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("endrop_dead0", 32'(dd[0]), 32'd0);
        clr();
        repeat (3) cyc(1'b1, 1'b1);
        chk("reen_dead0", 32'(dd_cnt[0]), 32'd2);
        chk("reen_high0", 32'(hi_cnt[0]), 32'd1);

        // 15-cycle dead interval on a clean side change
        repeat (20) cyc(1'b1, 1'b1);
        clr();
        repeat (25) cyc(1'b0, 1'b1);
        chk("dead15_len", 32'(dd_cnt[1]), 32'd15);

        // random segments
        for (int s = 0; s < 80; s++) begin
            int len;
            bit p, en;
            len = $urandom_range(1, 14);
            p   = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 14) != 0);
            repeat (len) cyc(p, en);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
